// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input truth-table sweeper: steps x_out through 0..15, holds each code
// HOLD_CYCLES cycles, captures y_in per code and counts mismatches against a latched golden table.
module truth_table_sweeper #(
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        y_in,
  output logic [3:0]  x_out,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [4:0] MM_MAX    = 5'd16;

  state_e      state_q, state_d;
  logic [3:0]  x_q, x_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] table_q, table_d;
  logic [15:0] exp_lat_q, exp_lat_d;
  logic [4:0]  mm_q, mm_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= 4'd0;
      cnt_q     <= 8'd0;
      table_q   <= 16'd0;
      exp_lat_q <= 16'd0;
      mm_q      <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      table_q   <= table_d;
      exp_lat_q <= exp_lat_d;
      mm_q      <= mm_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // Control: start is a level sampled on the rising edge and accepted only outside RUN;
  // abort is sampled only in RUN and wins over a simultaneous start there.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    table_d   = table_q;
    exp_lat_d = exp_lat_q;
    mm_d      = mm_q;
    busy_d    = busy_q;
    done_d    = done_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          x_d       = 4'd0;
          cnt_d     = 8'd0;
          table_d   = 16'd0;
          mm_d      = 5'd0;
          exp_lat_d = expected;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Partial table and count are kept for inspection after an abort.
          state_d = ST_IDLE;
          x_d     = 4'd0;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d          = 8'd0;
          table_d[x_q]   = y_in;
          if ((y_in != exp_lat_q[x_q]) && (mm_q != MM_MAX)) begin
            mm_d = mm_q + 5'd1;
          end
          if (x_q == 4'hF) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d = x_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = 4'd0;
        cnt_d   = 8'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    // Registered so pass never glitches with y_in.
    pass_d = done_d && (mm_d == 5'd0);
  end

  assign x_out        = x_q;
  assign table_out    = table_q;
  assign mismatch_cnt = mm_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;

endmodule
